eq2_lock_tracker: RTL and testbench

- Sequential stage directly downstream of the 2-bit equality comparator; consumes its z output one sample per valid cycle.
- Tracks runs of consecutive matches and mismatches; declares "lock" after LOCK_N consecutive matches and drops it after UNLOCK_N consecutive mismatches (hysteresis).
- Used to qualify comparator results, e.g. stream/pattern alignment, before downstream control logic acts on them.

---
 rtl/eq2_pkg.sv | 15 +
 rtl/eq2_lock_tracker_if.sv | 40 ++++
 rtl/sat_counter.sv | 22 ++
 rtl/eq2_lock_tracker.sv | 180 ++++++++++++++++++
 tb/tb_eq2_lock_tracker.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/eq2_pkg.sv
// eq2_pkg: shared types and default constants for the eq2 lock tracker.
// Optional statistics outputs are enabled by defining EQ2_LOCK_STATS_EN.
package eq2_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        SLIP   = 2'd2
    } eq2_lock_state_t;

    localparam int EQ2_LOCK_N   = 4;
    localparam int EQ2_UNLOCK_N = 2;
    localparam int EQ2_CNT_W    = 8;

endpackage

// File: rtl/eq2_lock_tracker_if.sv
// eq2_lock_tracker_if: comparator sample input and lock status bundle.
// Statistics signals exist only when EQ2_LOCK_STATS_EN is defined.
interface eq2_lock_tracker_if #(
    parameter int CNT_W = 8
);

    logic             valid;
    logic             z;
    logic             locked;
    logic             lock_pulse;
    logic             unlock_pulse;
    logic [CNT_W-1:0] streak;
`ifdef EQ2_LOCK_STATS_EN
    logic [CNT_W-1:0] lock_losses;
    logic [CNT_W-1:0] max_streak;

    modport master (
        output valid, z,
        input  locked, lock_pulse, unlock_pulse, streak,
        input  lock_losses, max_streak
    );

    modport slave (
        input  valid, z,
        output locked, lock_pulse, unlock_pulse, streak,
        output lock_losses, max_streak
    );
`else
    modport master (
        output valid, z,
        input  locked, lock_pulse, unlock_pulse, streak
    );

    modport slave (
        input  valid, z,
        output locked, lock_pulse, unlock_pulse, streak
    );
`endif

endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that holds at all-ones.
// Synchronous reset and clear share priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Clear wins over increment; increment stops at the maximum value.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/eq2_lock_tracker.sv
// eq2_lock_tracker: hysteretic lock detector on comparator match results.
// Define EQ2_LOCK_STATS_EN to add lock_losses and max_streak outputs.
module eq2_lock_tracker
    import eq2_pkg::*;
#(
    parameter int LOCK_N   = EQ2_LOCK_N,
    parameter int UNLOCK_N = EQ2_UNLOCK_N,
    parameter int CNT_W    = EQ2_CNT_W
) (
    input logic               clk,
    input logic               reset,
    eq2_lock_tracker_if.slave bus
);

    localparam logic [CNT_W-1:0] LOCK_V   = CNT_W'(LOCK_N);
    localparam logic [CNT_W-1:0] UNLOCK_V = CNT_W'(UNLOCK_N);
    localparam logic [CNT_W-1:0] MAX_V    = {CNT_W{1'b1}};

    eq2_lock_state_t  state;
    logic             locked;
    logic             lock_pulse;
    logic             unlock_pulse;
    logic [CNT_W-1:0] streak;
    logic [CNT_W-1:0] miss_run;
    logic [CNT_W-1:0] streak_inc;
    logic [CNT_W-1:0] miss_inc;
    logic             s_inc, s_clr;
    logic             m_inc, m_clr;
    logic             lock_now, unlock_now;

    assign streak_inc = (streak == MAX_V) ? streak : streak + CNT_W'(1);
    assign miss_inc   = miss_run + CNT_W'(1);

    // Counter controls and transition events for the current sample.
    always_comb begin
        s_inc      = 1'b0;
        s_clr      = 1'b0;
        m_inc      = 1'b0;
        m_clr      = 1'b0;
        lock_now   = 1'b0;
        unlock_now = 1'b0;
        unique case (state)
            SEARCH: begin
                if (bus.valid) begin
                    if (bus.z) begin
                        s_inc    = 1'b1;
                        lock_now = (streak_inc == LOCK_V);
                    end else begin
                        s_clr = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (bus.valid) begin
                    if (bus.z) begin
                        s_inc = 1'b1;
                        m_clr = 1'b1;
                    end else begin
                        s_clr = 1'b1;
                        if (UNLOCK_N == 1) begin
                            unlock_now = 1'b1;
                            m_clr      = 1'b1;
                        end else begin
                            m_inc = 1'b1;
                        end
                    end
                end
            end
            SLIP: begin
                if (bus.valid) begin
                    if (bus.z) begin
                        // streak is zero throughout SLIP, so this yields 1.
                        s_inc = 1'b1;
                        m_clr = 1'b1;
                    end else if (miss_inc == UNLOCK_V) begin
                        unlock_now = 1'b1;
                        m_clr      = 1'b1;
                    end else begin
                        m_inc = 1'b1;
                    end
                end
            end
            default: begin
                s_clr = 1'b1;
                m_clr = 1'b1;
            end
        endcase
    end

    // Lock state machine with registered status and pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SEARCH;
            locked       <= 1'b0;
            lock_pulse   <= 1'b0;
            unlock_pulse <= 1'b0;
        end else begin
            lock_pulse   <= lock_now;
            unlock_pulse <= unlock_now;
            unique case (state)
                SEARCH: begin
                    if (lock_now) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (unlock_now) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end else if (bus.valid && !bus.z) begin
                        state <= SLIP;
                    end
                end
                SLIP: begin
                    if (unlock_now) begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end else if (bus.valid && bus.z) begin
                        state <= LOCKED;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_streak (
        .clk   (clk),
        .reset (reset),
        .clr   (s_clr),
        .inc   (s_inc),
        .q     (streak)
    );

    sat_counter #(.W(CNT_W)) u_miss (
        .clk   (clk),
        .reset (reset),
        .clr   (m_clr),
        .inc   (m_inc),
        .q     (miss_run)
    );

    assign bus.locked       = locked;
    assign bus.lock_pulse   = lock_pulse;
    assign bus.unlock_pulse = unlock_pulse;
    assign bus.streak       = streak;

`ifdef EQ2_LOCK_STATS_EN
    logic [CNT_W-1:0] streak_d;
    logic [CNT_W-1:0] max_streak;
    logic [CNT_W-1:0] lock_losses;

    assign streak_d = s_clr ? '0 : (s_inc ? streak_inc : streak);

    // Track the largest streak in step with the streak register.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_streak <= '0;
        end else if (streak_d > max_streak) begin
            max_streak <= streak_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_losses (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (unlock_now),
        .q     (lock_losses)
    );

    assign bus.lock_losses = lock_losses;
    assign bus.max_streak  = max_streak;
`endif

endmodule

// File: tb/tb_eq2_lock_tracker.sv
// tb_eq2_lock_tracker: two tracker configurations against a behavioural model.
// Statistics outputs are also checked when EQ2_LOCK_STATS_EN is defined.
module tb_eq2_lock_tracker;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    eq2_lock_tracker_if #(.CNT_W(8)) bus0 ();
    eq2_lock_tracker_if #(.CNT_W(2)) bus1 ();

    eq2_lock_tracker #(
        .LOCK_N   (4),
        .UNLOCK_N (2),
        .CNT_W    (8)
    ) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    eq2_lock_tracker #(
        .LOCK_N   (3),
        .UNLOCK_N (1),
        .CNT_W    (2)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Per-instance model parameters: lock count, unlock count, max count.
    int p_ln [2] = '{4, 3};
    int p_un [2] = '{2, 1};
    int p_mx [2] = '{255, 3};

    // Model state: lock flag, pending misses, outputs and statistics.
    int m_lk [2];
    int m_miss [2];
    int m_st [2];
    int m_lp [2];
    int m_up [2];
    int m_loss [2];
    int m_max [2];

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model(input int i, input bit r, input bit v, input bit zz);
        m_lp[i] = 0;
        m_up[i] = 0;
        if (r) begin
            m_lk[i]   = 0;
            m_miss[i] = 0;
            m_st[i]   = 0;
            m_loss[i] = 0;
            m_max[i]  = 0;
        end else if (v) begin
            if (zz) begin
                if (m_lk[i] != 0 && m_miss[i] > 0) m_st[i] = 1;
                else if (m_st[i] < p_mx[i]) m_st[i]++;
                m_miss[i] = 0;
                if (m_lk[i] == 0 && m_st[i] == p_ln[i]) begin
                    m_lk[i] = 1;
                    m_lp[i] = 1;
                end
            end else begin
                m_st[i] = 0;
                if (m_lk[i] != 0) begin
                    m_miss[i]++;
                    if (m_miss[i] == p_un[i]) begin
                        m_lk[i]   = 0;
                        m_miss[i] = 0;
                        m_up[i]   = 1;
                        if (m_loss[i] < p_mx[i]) m_loss[i]++;
                    end
                end
            end
            if (m_st[i] > m_max[i]) m_max[i] = m_st[i];
        end
    endtask

    task automatic step(input bit r, input bit v, input bit zz);
        @(negedge clk);
        reset      = r;
        bus0.valid = v;
        bus0.z     = zz;
        bus1.valid = v;
        bus1.z     = zz;
        @(posedge clk);
        #1;
        model(0, r, v, zz);
        model(1, r, v, zz);
        check("i0 locked", int'(bus0.locked), m_lk[0]);
        check("i0 lock_pulse", int'(bus0.lock_pulse), m_lp[0]);
        check("i0 unlock_pulse", int'(bus0.unlock_pulse), m_up[0]);
        check("i0 streak", int'(bus0.streak), m_st[0]);
        check("i1 locked", int'(bus1.locked), m_lk[1]);
        check("i1 lock_pulse", int'(bus1.lock_pulse), m_lp[1]);
        check("i1 unlock_pulse", int'(bus1.unlock_pulse), m_up[1]);
        check("i1 streak", int'(bus1.streak), m_st[1]);
        check("i0 pulse excl", int'(bus0.lock_pulse & bus0.unlock_pulse), 0);
`ifdef EQ2_LOCK_STATS_EN
        check("i0 lock_losses", int'(bus0.lock_losses), m_loss[0]);
        check("i0 max_streak", int'(bus0.max_streak), m_max[0]);
        check("i1 lock_losses", int'(bus1.lock_losses), m_loss[1]);
        check("i1 max_streak", int'(bus1.max_streak), m_max[1]);
`endif
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) step(1'b0, 1'b1, bits[k]);
    endtask

    initial begin
        reset      = 1'b1;
        bus0.valid = 1'b0;
        bus0.z     = 1'b0;
        bus1.valid = 1'b0;
        bus1.z     = 1'b0;

        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        feed(16'b1111, 4);
        step(1'b0, 1'b0, 1'b0);
        feed(16'b0100, 4);
        feed(16'b1110_1111, 8);

        step(1'b1, 1'b0, 1'b0);
        feed(16'b111, 3);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, k[0]);
        feed(16'b1, 1);

        step(1'b1, 1'b0, 1'b0);
        feed(16'b1111, 4);
        feed(16'b0, 1);
        step(1'b1, 1'b0, 1'b0);
        feed(16'b0, 1);
        feed(16'b11111, 5);

        feed(16'b00, 2);
        feed(16'b1111, 4);
        feed(16'b00, 2);

        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 80,
                 $urandom_range(0, 99) < 70);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
